// File: rtl/otter_htif_mailbox.sv
// Host-target mailbox on the OtterMCU data bus: tohost/fromhost words, status, console FIFO.
// Optional macro OTTER_HTIF_IRQ_EN adds an irq output and STATUS[8] console irq enable.
module otter_htif_mailbox #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          CONS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_r_en,
    input  logic        dmem_w_en,
    input  logic [3:0]  dmem_w_strb,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_w_data,
    output logic [31:0] dmem_r_data,
    output logic        tohost_valid,
    input  logic        tohost_ready,
    output logic [31:0] tohost_data,
    input  logic        fromhost_valid,
    output logic        fromhost_ready,
    input  logic [31:0] fromhost_data,
    output logic        cons_valid,
    input  logic        cons_ready,
    output logic [7:0]  cons_data
`ifdef OTTER_HTIF_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int AW = $clog2(CONS_DEPTH);

    typedef enum logic {IDLE, PEND} th_state_t;

    th_state_t   state_q, state_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] fromhost_q;
    logic [31:0] status;
    logic        ovf_q, drop_q, ovf_set;
    logic        irq_en_q;
    logic        sel, wr_th, wr_fh, wr_st, push_req, push_ok, pop, drop_set;
    logic        cons_empty, cons_full;
    logic [AW:0] wptr, rptr;
    logic [7:0]  mem [CONS_DEPTH];
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^dmem_addr[1:0];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

    assign sel      = (dmem_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_th    = dmem_w_en && sel && (dmem_addr[3:2] == 2'd0);
    assign wr_fh    = dmem_w_en && sel && (dmem_addr[3:2] == 2'd1);
    assign wr_st    = dmem_w_en && sel && (dmem_addr[3:2] == 2'd2);
    assign push_req = dmem_w_en && sel && (dmem_addr[3:2] == 2'd3) && dmem_w_strb[0];

    // tohost FSM: any write landing while PEND (even on the handshake edge) is an overflow
    always_comb begin
        state_d  = state_q;
        tohost_d = tohost_q;
        ovf_set  = 1'b0;
        case (state_q)
            IDLE: if (wr_th) begin
                tohost_d = merge(tohost_q, dmem_w_data, dmem_w_strb);
                if (tohost_d != 32'd0) state_d = PEND;
            end
            PEND: begin
                ovf_set = wr_th;
                if (tohost_ready) begin
                    tohost_d = 32'd0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q  <= IDLE;
            tohost_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            tohost_q <= tohost_d;
        end

    assign tohost_valid   = (state_q == PEND);
    assign tohost_data    = tohost_q;
    assign fromhost_ready = (fromhost_q == 32'd0);

    // Host accept takes priority over a same-cycle core write
    always_ff @(posedge clk or negedge rst)
        if (!rst)                                 fromhost_q <= 32'd0;
        else if (fromhost_valid && fromhost_ready) fromhost_q <= fromhost_data;
        else if (wr_fh)                            fromhost_q <= merge(fromhost_q, dmem_w_data, dmem_w_strb);

    // Console FIFO; extra pointer bit distinguishes full from empty
    assign cons_empty = (wptr == rptr);
    assign cons_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop        = !cons_empty && cons_ready;
    assign push_ok    = push_req && (!cons_full || pop);
    assign drop_set   = push_req && cons_full && !pop;
    assign cons_valid = !cons_empty;
    assign cons_data  = cons_empty ? 8'd0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk)
        if (push_ok) mem[wptr[AW-1:0]] <= dmem_w_data[7:0];

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            ovf_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            if (ovf_set)                                         ovf_q  <= 1'b1;
            else if (wr_st && dmem_w_strb[0] && dmem_w_data[4])  ovf_q  <= 1'b0;
            if (drop_set)                                        drop_q <= 1'b1;
            else if (wr_st && dmem_w_strb[0] && dmem_w_data[5])  drop_q <= 1'b0;
        end

`ifdef OTTER_HTIF_IRQ_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_st && dmem_w_strb[1]) irq_en_q <= dmem_w_data[8];
            irq <= (fromhost_q != 32'd0) | (cons_empty & irq_en_q);
        end
`else
    assign irq_en_q = 1'b0;
`endif

    always_comb begin
        status    = 32'd0;
        status[0] = (state_q == PEND);
        status[1] = (fromhost_q != 32'd0);
        status[2] = cons_full;
        status[3] = cons_empty;
        status[4] = ovf_q;
        status[5] = drop_q;
        status[8] = irq_en_q;
    end

    // Registered read sees pre-write register values
    always_ff @(posedge clk or negedge rst)
        if (!rst) dmem_r_data <= 32'd0;
        else if (dmem_r_en) begin
            if (!sel) dmem_r_data <= 32'd0;
            else case (dmem_addr[3:2])
                2'd0:    dmem_r_data <= tohost_q;
                2'd1:    dmem_r_data <= fromhost_q;
                2'd2:    dmem_r_data <= status;
                default: dmem_r_data <= 32'd0;
            endcase
        end
endmodule

// File: tb/tb_otter_htif_mailbox.sv
// Randomized + directed bench for otter_htif_mailbox against a queue-based mailbox model.
module tb_otter_htif_mailbox;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0, rst = 1'b0;
    logic        dmem_r_en, dmem_w_en, tohost_ready, fromhost_valid, cons_ready;
    logic [3:0]  dmem_w_strb;
    logic [31:0] dmem_addr, dmem_w_data, fromhost_data;
    logic [31:0] dmem_r_data, tohost_data;
    logic        tohost_valid, fromhost_ready, cons_valid;
    logic [7:0]  cons_data;
`ifdef OTTER_HTIF_IRQ_EN
    logic        irq;
`endif

    otter_htif_mailbox #(.BASE_ADDR(BASE), .CONS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .dmem_r_en(dmem_r_en), .dmem_w_en(dmem_w_en), .dmem_w_strb(dmem_w_strb),
        .dmem_addr(dmem_addr), .dmem_w_data(dmem_w_data), .dmem_r_data(dmem_r_data),
        .tohost_valid(tohost_valid), .tohost_ready(tohost_ready), .tohost_data(tohost_data),
        .fromhost_valid(fromhost_valid), .fromhost_ready(fromhost_ready),
        .fromhost_data(fromhost_data),
        .cons_valid(cons_valid), .cons_ready(cons_ready), .cons_data(cons_data)
`ifdef OTTER_HTIF_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // Reference model: mailbox contents as plain values and a byte queue
    bit          m_pend, m_ovf, m_drop, m_irq_en, m_irq;
    logic [31:0] m_th, m_fh, m_rdata;
    logic [7:0]  m_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'd0;
        if (m_pend)                s = s | 32'h01;
        if (m_fh != 0)             s = s | 32'h02;
        if (m_q.size() == DEPTH)   s = s | 32'h04;
        if (m_q.size() == 0)       s = s | 32'h08;
        if (m_ovf)                 s = s | 32'h10;
        if (m_drop)                s = s | 32'h20;
        if (m_irq_en)              s = s | 32'h100;
        return s;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_ovf = 0; m_drop = 0; m_irq_en = 0; m_irq = 0;
        m_th = 0; m_fh = 0; m_rdata = 0;
        m_q.delete();
    endtask

    // One clock edge of mailbox behaviour, from the inputs currently driven
    task automatic model_next();
        bit          is_sel, wr, fire, accept, pop;
        int          idx, pre_size;
        logic [31:0] mask, v;
        is_sel   = (dmem_addr[31:4] == BASE[31:4]);
        idx      = int'(dmem_addr[3:2]);
        wr       = dmem_w_en && is_sel;
        mask     = bmask(dmem_w_strb);
        fire     = m_pend && tohost_ready;
        accept   = (m_fh == 0) && fromhost_valid;
        pre_size = m_q.size();
        pop      = (pre_size > 0) && cons_ready;
        if (dmem_r_en)
            m_rdata = !is_sel ? 32'd0 : (idx == 0) ? m_th : (idx == 1) ? m_fh :
                      (idx == 2) ? m_status() : 32'd0;
`ifdef OTTER_HTIF_IRQ_EN
        m_irq = (m_fh != 0) || (pre_size == 0 && m_irq_en);
`endif
        if (wr && idx == 0) begin
            if (m_pend) m_ovf = 1;
            else begin
                v = (m_th & ~mask) | (dmem_w_data & mask);
                m_th = v;
                m_pend = (v != 0);
            end
        end
        if (fire) begin m_pend = 0; m_th = 0; end
        if (accept)                 m_fh = fromhost_data;
        else if (wr && idx == 1)    m_fh = (m_fh & ~mask) | (dmem_w_data & mask);
        if (wr && idx == 2) begin
            if (dmem_w_strb[0] && dmem_w_data[4]) m_ovf  = 0;
            if (dmem_w_strb[0] && dmem_w_data[5]) m_drop = 0;
`ifdef OTTER_HTIF_IRQ_EN
            if (dmem_w_strb[1]) m_irq_en = dmem_w_data[8];
`endif
        end
        if (pop) void'(m_q.pop_front());
        if (wr && idx == 3 && dmem_w_strb[0]) begin
            if (pre_size == DEPTH && !pop) m_drop = 1;
            else m_q.push_back(dmem_w_data[7:0]);
        end
    endtask

    task automatic check_outs();
        chk("tohost_valid",   {31'd0, tohost_valid},   {31'd0, m_pend});
        chk("tohost_data",    tohost_data,             m_th);
        chk("fromhost_ready", {31'd0, fromhost_ready}, {31'd0, m_fh == 0});
        chk("cons_valid",     {31'd0, cons_valid},     {31'd0, m_q.size() > 0});
        chk("cons_data",      {24'd0, cons_data},      {24'd0, (m_q.size() > 0) ? m_q[0] : 8'd0});
        chk("dmem_r_data",    dmem_r_data,             m_rdata);
`ifdef OTTER_HTIF_IRQ_EN
        chk("irq",            {31'd0, irq},            {31'd0, m_irq});
`endif
    endtask

    // Called at a falling edge with inputs already driven
    task automatic step();
        model_next();
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    task automatic bus_idle();
        dmem_r_en = 0; dmem_w_en = 0; dmem_w_strb = 0; dmem_addr = 0; dmem_w_data = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dmem_w_en = 1; dmem_addr = a; dmem_w_data = d; dmem_w_strb = s;
        step();
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] a);
        dmem_r_en = 1; dmem_addr = a;
        step();
        bus_idle();
    endtask

    initial begin
        bus_idle();
        tohost_ready = 0; fromhost_valid = 0; fromhost_data = 0; cons_ready = 0;
        model_reset();
        #2;
        check_outs();
        chk("rst_fromhost_ready", {31'd0, fromhost_ready}, 32'd1);
        @(negedge clk);
        rst = 1;

        // tohost post and handshake
        wr(BASE, 32'h1, 4'hF);
        chk("th_valid_set", {31'd0, tohost_valid}, 32'd1);
        chk("th_data_set", tohost_data, 32'h1);
        rd(BASE + 32'h8);
        chk("status_pend", dmem_r_data, 32'h9);
        tohost_ready = 1;
        step();
        tohost_ready = 0;
        chk("th_valid_clr", {31'd0, tohost_valid}, 32'd0);
        rd(BASE);
        chk("th_read_zero", dmem_r_data, 32'h0);

        // overflow while pending, then clear sticky
        wr(BASE, 32'h1, 4'hF);
        wr(BASE, 32'h5, 4'hF);
        chk("th_data_kept", tohost_data, 32'h1);
        rd(BASE + 32'h8);
        chk("status_ovf", dmem_r_data, 32'h19);
        wr(BASE + 32'h8, 32'h10, 4'h1);
        rd(BASE + 32'h8);
        chk("status_ovf_clr", dmem_r_data, 32'h09);
        tohost_ready = 1;
        step();
        tohost_ready = 0;

        // fromhost
        fromhost_valid = 1; fromhost_data = 32'hDEAD_BEEF;
        step();
        fromhost_valid = 0;
        chk("fh_ready_low", {31'd0, fromhost_ready}, 32'd0);
        rd(BASE + 32'h4);
        chk("fh_read", dmem_r_data, 32'hDEAD_BEEF);
        wr(BASE + 32'h4, 32'h0, 4'hF);
        chk("fh_ready_free", {31'd0, fromhost_ready}, 32'd1);
        fromhost_valid = 1; fromhost_data = 32'h7;
        wr(BASE + 32'h4, 32'h0, 4'hF);
        fromhost_valid = 0;
        rd(BASE + 32'h4);
        chk("fh_host_wins", dmem_r_data, 32'h7);
        wr(BASE + 32'h4, 32'h0, 4'hF);

        // console overfill then drain
        for (int i = 0; i < 9; i++) wr(BASE + 32'hC, 32'h41 + i, 4'h1);
        rd(BASE + 32'h8);
        chk("status_full_drop", dmem_r_data, 32'h24);
        for (int i = 0; i < 8; i++) begin
            chk("cons_order", {24'd0, cons_data}, 32'h41 + i);
            cons_ready = 1;
            step();
            cons_ready = 0;
        end
        chk("cons_drained", {31'd0, cons_valid}, 32'd0);
        wr(BASE + 32'h8, 32'h20, 4'h1);

        // ignored writes and unselected read
        wr(BASE + 32'hC, 32'h55, 4'hE);
        wr(BASE + 32'h10, 32'h77, 4'hF);
        chk("cons_no_push", {31'd0, cons_valid}, 32'd0);
        rd(BASE + 32'h8);
        chk("status_idle", dmem_r_data, 32'h8);
        rd(32'h1000_0008);
        chk("unsel_read", dmem_r_data, 32'h0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int k;
            dmem_r_en = ($urandom_range(0, 2) == 0);
            dmem_w_en = ($urandom_range(0, 1) == 0);
            dmem_addr = ($urandom_range(0, 9) == 0) ? $urandom()
                        : (BASE | {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
            k = $urandom_range(0, 3);
            dmem_w_data = (k == 0) ? 32'd0 : (k == 1) ? 32'($urandom_range(1, 255)) :
                          (k == 2) ? 32'h30 : $urandom();
            dmem_w_strb = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            tohost_ready   = ($urandom_range(0, 2) == 0);
            fromhost_valid = ($urandom_range(0, 3) == 0);
            fromhost_data  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            cons_ready     = ($urandom_range(0, 2) == 0);
            step();
        end
        bus_idle();
        tohost_ready = 0; fromhost_valid = 0; cons_ready = 0;
        fromhost_data = 0;

        // async reset with FIFO and tohost busy
        wr(BASE + 32'h4, 32'h0, 4'hF);
        wr(BASE + 32'h8, 32'h30, 4'h1);
        while (m_q.size() > 0) begin cons_ready = 1; step(); end
        cons_ready = 0;
        if (m_pend) begin tohost_ready = 1; step(); tohost_ready = 0; end
        for (int i = 0; i < 3; i++) wr(BASE + 32'hC, 32'h60 + i, 4'h1);
        wr(BASE, 32'h3, 4'hF);
        rd(BASE + 32'h8);
        chk("pre_rst_status", dmem_r_data, 32'h1);
        @(posedge clk);
        #2;
        rst = 0;
        #1;
        model_reset();
        check_outs();
        chk("rst_mid_th_valid", {31'd0, tohost_valid}, 32'd0);
        chk("rst_mid_fh_ready", {31'd0, fromhost_ready}, 32'd1);
        @(negedge clk);
        rst = 1;
        rd(BASE + 32'h8);
        chk("post_rst_status", dmem_r_data, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/otter_htif_mailbox.md
Name: otter_htif_mailbox

Overview:
- Synthesizable responder on the OtterMCU data-memory bus implementing the host-target mailbox: tohost, fromhost, status and console registers.
- The core writes tohost to signal test end or a syscall. A host-side agent (FPGA bridge or bench) consumes it over valid/ready, returns replies through fromhost, and drains a console byte FIFO.
- Sits beside data memory; the integration selects it by address.

Parameters:
- BASE_ADDR, 32'h8000_0000: byte address of the 16-byte register window; bits [3:0] must be 0.
- CONS_DEPTH, 8: console FIFO depth in bytes; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- dmem_r_en  in  1  core read request
- dmem_w_en  in  1  core write request
- dmem_w_strb  in  4  byte write strobes
- dmem_addr  in  32  byte address
- dmem_w_data  in  32  write data
- dmem_r_data  out  32  read data, registered
- tohost_valid  out  1  tohost word pending for the host
- tohost_ready  in  1  host accepts tohost
- tohost_data  out  32  pending tohost word
- fromhost_valid  in  1  host offers a reply
- fromhost_ready  out  1  fromhost register empty
- fromhost_data  in  32  reply word
- cons_valid  out  1  console byte available
- cons_ready  in  1  host pops a console byte
- cons_data  out  8  head console byte

Behaviour:
- Reset (rst=0, async): all outputs 0, except fromhost_ready=1; registers cleared; FIFO empty; state IDLE.
- Decode: sel = (dmem_addr[31:4] == BASE_ADDR[31:4]). Offsets by dmem_addr[3:2]: 0 TOHOST, 1 FROMHOST, 2 STATUS, 3 CONSOLE.
- Read, 1-cycle latency: on the clk edge with dmem_r_en=1, dmem_r_data <= selected register, or 0 if not sel. CONSOLE reads return 0. Without r_en, dmem_r_data holds.
- STATUS bits: [0] tohost_pending, [1] fromhost_full, [2] cons_full, [3] cons_empty, [4] tohost_ovf (sticky), [5] cons_drop (sticky). All others 0.
- STATUS write: 1 to bit 4 or 5 clears it; other bits read-only.
- tohost FSM, IDLE and PEND:
  - IDLE: a TOHOST write merges strobed bytes. If the merged value != 0, go to PEND on the same edge; the register keeps the value.
  - PEND: tohost_valid=1 and tohost_data=register. On tohost_valid & tohost_ready: register <= 0, go to IDLE.
  - A TOHOST write in PEND is dropped and sets tohost_ovf. This includes a write in the same cycle as the handshake, which is dropped.
  - A zero write in IDLE updates the register and stays in IDLE.
- fromhost:
  - fromhost_ready = (fromhost_reg == 0).
  - On fromhost_valid & fromhost_ready: load fromhost_data. A zero word is accepted and has no effect.
  - Core writes merge strobed bytes, so writing 0 frees the slot.
  - Core write and host accept in the same cycle: host data wins and the core write is discarded.
- Console FIFO:
  - A CONSOLE write with strb[0]=1 pushes dmem_w_data[7:0]. Writes with strb[0]=0 are ignored.
  - Pointers have log2(CONS_DEPTH)+1 bits and wrap modulo 2*CONS_DEPTH.
  - A push when full is dropped and sets cons_drop.
  - cons_valid = !empty; cons_data = head byte, combinational from storage.
  - Pop on cons_valid & cons_ready.
  - Simultaneous push and pop when full: the pop frees a slot and the push succeeds, so no drop.
  - Simultaneous push and pop when empty: the pushed byte becomes visible next cycle.
- Other rules:
  - Writes with dmem_w_en=1 and not sel have no effect.
  - A read and a write to the same register in the same cycle: the read returns the pre-write value.
  - Reset asserted mid-operation clears everything immediately. Pending tohost and FIFO contents are lost.

Optional Feature:
- Macro: OTTER_HTIF_IRQ_EN.
- Defined: adds output port irq (1 bit), a register reset to 0, set to (fromhost_reg != 0) | (cons_empty & cons_irq_en). The core feeds it into intrpt[11] (MEIP).
  - cons_irq_en is STATUS bit [8], read/write, reset 0.
  - irq updates one cycle after the condition changes.
- Undefined: no irq port; STATUS[8] reads 0 and writes are ignored.

Test Plan:
- Write 0x0000_0001 to BASE+0x0 with strb 4'hF, tohost_ready=0 -> next cycle tohost_valid=1, tohost_data=0x1. Read BASE+0x8 -> 0x0000_0009, i.e. pending plus cons_empty. Raise tohost_ready -> the following cycle tohost_valid=0; BASE+0x0 reads 0.
- While PEND, write 0x5 to tohost -> tohost_data stays 0x1 and STATUS[4]=1. Write 0x10 to STATUS -> STATUS[4]=0.
- Host drives fromhost_valid with 0xDEAD_BEEF -> fromhost_ready drops next cycle; BASE+0x4 reads 0xDEAD_BEEF. Core writes 0 -> fromhost_ready=1. Same-cycle core write 0 plus host write 0x7 while empty -> register=0x7.
- Push 9 bytes 0x41..0x49 to BASE+0xC with CONS_DEPTH=8 and cons_ready=0 -> STATUS[2]=1, STATUS[5]=1. Pop 8 -> bytes 0x41..0x48 in order, then cons_valid=0.
- Write to BASE+0xC with strb 4'hE, and a write to BASE+0x10 -> no FIFO change, no register change, no sticky bits. A read of an unselected address returns 0 after 1 cycle.
- With the FIFO holding 3 bytes and tohost pending, assert rst=0 asynchronously mid-cycle -> all outputs 0 immediately except fromhost_ready=1. After release, STATUS reads 0x8.
